// File: rtl/edge_pattern_gen.sv
// Programmable gated-clock pattern generator: emits n_periods of hi_len/lo_len
// cycles on a registered gclk, with edge-event strobes, busy and done.
// Optional macro EDGE_PATTERN_GEN_INV_OUT_EN adds a registered gclk_n output.
module edge_pattern_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] hi_len,
  input  logic [CNT_W-1:0] lo_len,
  input  logic [CNT_W-1:0] n_periods,
  output logic             gclk,
  output logic             pos_evt,
  output logic             neg_evt,
  output logic             busy,
  output logic             done
`ifdef EDGE_PATTERN_GEN_INV_OUT_EN
  ,
  output logic             gclk_n
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, next_state;
  logic [CNT_W-1:0] hi_q, lo_q, n_q;
  logic [CNT_W-1:0] ph_cnt, ph_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt, per_inc;
  logic             stop_pend, pend_nxt;
  logic             done_nxt;
  logic             ld;
  logic [CNT_W-1:0] hi_eff, lo_eff;

  // A zero phase length would stall the pattern, so it is stretched to one cycle.
  assign hi_eff  = (hi_q == '0) ? ONE : hi_q;
  assign lo_eff  = (lo_q == '0) ? ONE : lo_q;
  assign per_inc = per_cnt + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      n_q       <= '0;
      ph_cnt    <= '0;
      per_cnt   <= '0;
      stop_pend <= 1'b0;
      gclk      <= 1'b0;
      pos_evt   <= 1'b0;
      neg_evt   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      ph_cnt    <= ph_nxt;
      per_cnt   <= per_nxt;
      stop_pend <= pend_nxt;
      if (ld) begin
        hi_q <= hi_len;
        lo_q <= lo_len;
        n_q  <= n_periods;
      end
      // Outputs are registered from the next state so they align with it.
      gclk    <= (next_state == HIGH);
      pos_evt <= (next_state == HIGH) && (state != HIGH);
      neg_evt <= (next_state == LOW) && (state != LOW);
      busy    <= (next_state != IDLE);
      done    <= done_nxt;
    end
  end

`ifdef EDGE_PATTERN_GEN_INV_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gclk_n <= 1'b0;
    else     gclk_n <= (next_state == LOW);
  end
`endif

  always_comb begin
    next_state = state;
    ph_nxt     = ph_cnt;
    per_nxt    = per_cnt;
    pend_nxt   = stop_pend;
    done_nxt   = 1'b0;
    ld         = 1'b0;
    case (state)
      IDLE: begin
        // stop is ignored here, including when it arrives together with start.
        pend_nxt = 1'b0;
        if (start) begin
          ld         = 1'b1;
          ph_nxt     = '0;
          per_nxt    = '0;
          next_state = HIGH;
        end
      end
      HIGH: begin
        if (stop) pend_nxt = 1'b1;
        if (ph_cnt == hi_eff - ONE) begin
          ph_nxt     = '0;
          next_state = LOW;
        end else begin
          ph_nxt = ph_cnt + ONE;
        end
      end
      LOW: begin
        if (stop) pend_nxt = 1'b1;
        if (ph_cnt == lo_eff - ONE) begin
          ph_nxt  = '0;
          per_nxt = per_inc;
          if (((n_q != '0) && (per_inc == n_q)) || stop_pend || stop) begin
            next_state = IDLE;
            done_nxt   = 1'b1;
            pend_nxt   = 1'b0;
          end else begin
            next_state = HIGH;
          end
        end else begin
          ph_nxt = ph_cnt + ONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Directed bench for edge_pattern_gen: a per-cycle expected output queue is
// built from the pattern parameters and popped once per clk cycle.
module tb_edge_pattern_gen;

  localparam int CNT_W = 8;
  localparam int VW    = 5; // {gclk, pos_evt, neg_evt, busy, done}

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic [CNT_W-1:0] n_periods;
  logic             gclk, pos_evt, neg_evt, busy, done;
`ifdef EDGE_PATTERN_GEN_INV_OUT_EN
  logic             gclk_n;
`endif

  logic [VW-1:0] exp_q[$];
  int total;
  int bad;

  edge_pattern_gen #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .hi_len    (hi_len),
    .lo_len    (lo_len),
    .n_periods (n_periods),
    .gclk      (gclk),
    .pos_evt   (pos_evt),
    .neg_evt   (neg_evt),
    .busy      (busy),
    .done      (done)
`ifdef EDGE_PATTERN_GEN_INV_OUT_EN
    ,
    .gclk_n    (gclk_n)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected trace of one complete pattern: every period is hi cycles high then
  // lo cycles low (zero lengths count as one), followed by a single done cycle.
  task automatic push_pattern(input int hi, input int lo, input int periods);
    int h;
    int l;
    h = (hi == 0) ? 1 : hi;
    l = (lo == 0) ? 1 : lo;
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back({1'b1, (i == 0), 1'b0, 1'b1, 1'b0});
      for (int i = 0; i < l; i++) exp_q.push_back({1'b0, 1'b0, (i == 0), 1'b1, 1'b0});
    end
    exp_q.push_back(5'b00001);
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] e);
    logic [VW-1:0] obs;
    obs = {gclk, pos_evt, neg_evt, busy, done};
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed gclk/pos/neg/busy/done=%b expected=%b at %0t", tag, obs, e, $time);
    end
`ifdef EDGE_PATTERN_GEN_INV_OUT_EN
    total++;
    assert (gclk_n === (e[1] & ~e[4])) else begin
      bad++;
      $error("FAIL %s_gclk_n: observed=%b expected=%b at %0t", tag, gclk_n, e[1] & ~e[4], $time);
    end
`endif
  endtask

  // Advance one cycle and compare against the next queued expectation (idle if empty).
  task automatic tick(input string tag);
    logic [VW-1:0] e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
    check_vec(tag, e);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      tick(tag);
      guard++;
    end
    tick({tag, "_idle"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    hi_len = '0; lo_len = '0; n_periods = '0;
    #12;
    check_vec("reset_state", 5'b00000);
    #5 rst = 1'b0;
    tick("post_reset");

    // stop in IDLE has no effect
    stop = 1'b1;
    tick("stop_idle");
    stop = 1'b0;
    tick("stop_idle2");

    // hi=2 lo=3 n=2; inputs changed and start pulsed while busy
    hi_len = 8'd2; lo_len = 8'd3; n_periods = 8'd2;
    push_pattern(2, 3, 2);
    start = 1'b1;
    tick("p23_first");
    start = 1'b0;
    hi_len = 8'd7; lo_len = 8'd9; n_periods = 8'd5;
    tick("p23");
    tick("p23");
    start = 1'b1;
    tick("p23_busy_start");
    start = 1'b0;
    drain("p23");

    // zero lengths stretched to one cycle; start and stop together in IDLE
    hi_len = 8'd0; lo_len = 8'd0; n_periods = 8'd3;
    push_pattern(0, 0, 3);
    start = 1'b1; stop = 1'b1;
    tick("p00_first");
    start = 1'b0; stop = 1'b0;
    drain("p00");

    // continuous mode runs across the period-counter wrap, ended by stop in HIGH
    hi_len = 8'd1; lo_len = 8'd1; n_periods = 8'd0;
    push_pattern(1, 1, 300);
    start = 1'b1;
    tick("cont_first");
    start = 1'b0;
    repeat (598) tick("cont");
    stop = 1'b1;
    tick("cont_stop");
    stop = 1'b0;
    drain("cont");

    // reset mid-HIGH: outputs clear at once, no neg_evt/done afterwards
    hi_len = 8'd4; lo_len = 8'd2; n_periods = 8'd1;
    push_pattern(4, 2, 1);
    start = 1'b1;
    tick("rst_first");
    start = 1'b0;
    tick("rst_high");
    #2 rst = 1'b1;
    #1 check_vec("rst_async", 5'b00000);
    exp_q.delete();
    #2 rst = 1'b0;
    tick("rst_after");
    tick("rst_after2");
    push_pattern(4, 2, 1);
    start = 1'b1;
    tick("rst_restart");
    start = 1'b0;
    drain("rst_restart");

    // start held through the done cycle restarts immediately
    hi_len = 8'd1; lo_len = 8'd2; n_periods = 8'd1;
    push_pattern(1, 2, 1);
    push_pattern(1, 2, 1);
    start = 1'b1;
    repeat (5) tick("hold_start");
    start = 1'b0;
    drain("hold_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_pattern_gen.md
EDGE_PATTERN_GEN -- requirements
Module: edge_pattern_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of phase-length and period-count fields.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a pattern; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: request to end a running pattern gracefully.
REQ-006 The block SHALL have port hi_len, input, CNT_W bits: gclk high-phase length in clk cycles.
REQ-007 The block SHALL have port lo_len, input, CNT_W bits: gclk low-phase length in clk cycles.
REQ-008 The block SHALL have port n_periods, input, CNT_W bits: number of full gclk periods to emit; 0 = continuous.
REQ-009 The block SHALL have port gclk, output, 1 bit: the generated, registered, glitch-free edge pattern.
REQ-010 The block SHALL have port pos_evt, output, 1 bit: high for exactly the cycle in which gclk first reads 1 after being 0.
REQ-011 The block SHALL have port neg_evt, output, 1 bit: high for exactly the cycle in which gclk first reads 0 after being 1.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in state HIGH or LOW.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a pattern completes.

Function
REQ-014 The FSM SHALL have states IDLE, HIGH, LOW; gclk = 1 only in HIGH.
REQ-015 In IDLE, start=1 at cycle T SHALL latch hi_len, lo_len, n_periods, clear the period counter, and enter HIGH at T+1 with gclk=1, pos_evt=1, busy=1.
REQ-016 A latched hi_len or lo_len of 0 SHALL be treated as 1.
REQ-017 HIGH SHALL last exactly hi_len cycles, then LOW SHALL be entered with gclk=0 and neg_evt=1 in its first cycle.
REQ-018 LOW SHALL last exactly lo_len cycles; at its end the period counter SHALL increment (wrapping modulo 2^CNT_W).
REQ-019 At the end of LOW, if n_periods != 0 and the incremented count equals n_periods, or a stop is pending, the FSM SHALL enter IDLE with done=1 for one cycle; otherwise it SHALL re-enter HIGH with pos_evt=1.
REQ-020 stop=1 in HIGH or LOW SHALL set a pending flag; the current period SHALL complete in full, so every posedge has a matching negedge.
REQ-021 stop in IDLE SHALL be ignored; start while busy SHALL be ignored; start and stop in the same IDLE cycle SHALL start the pattern and ignore stop.
REQ-022 start in the done cycle (already IDLE) SHALL be accepted, giving gclk=1 on the next cycle.
REQ-023 Input changes to hi_len/lo_len/n_periods while busy SHALL have no effect until the next start.
REQ-024 In continuous mode (n_periods=0), the pattern SHALL run until stop; counter wrap SHALL not end it.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, gclk=0, pos_evt=0, neg_evt=0, busy=0, done=0, counter=0, stop-pending=0.
REQ-026 Reset mid-pattern SHALL not produce neg_evt or done; the first cycle after deassertion SHALL be IDLE.

Configuration
REQ-027 With macro EDGE_PATTERN_GEN_INV_OUT_EN defined, the block SHALL add output gclk_n (1 bit), registered, equal to ~gclk while busy and 0 in IDLE and reset; without it, gclk_n SHALL not exist and behaviour is otherwise identical.

Verification
REQ-028 hi_len=2, lo_len=3, n_periods=2, start at T -> gclk 1 at T+1..T+2, 0 at T+3..T+5, 1 at T+6..T+7, 0 at T+8..T+10, done=1 at T+11; two pos_evt, two neg_evt.
REQ-029 hi_len=0, lo_len=0, n_periods=3 -> gclk toggles every cycle, 3 periods, done at T+7.
REQ-030 n_periods=0, hi=1, lo=1, stop asserted while gclk=1 -> current low phase completes, then done; no further pos_evt.
REQ-031 rst asserted mid-HIGH -> gclk=0 immediately, no neg_evt, no done; start after release restarts from HIGH.
REQ-032 start held high through done cycle -> new pattern begins at done+1 with pos_evt; start during busy -> no effect on timing.
REQ-033 With EDGE_PATTERN_GEN_INV_OUT_EN, scenario REQ-028 -> gclk_n complement of gclk at T+1..T+10, 0 at T and T+11.
